// File: rtl/uart_sram_tx_interface_pkg.sv
// State types and UART framing constants shared by the SRAM-side interfaces.
// UART_TX_PARITY_EN switches the transmit framing from 8N1 to 8E1.
package uart_sram_tx_interface_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE_UART_RX,
    S_WAIT_UART_RX,
    S_VGA,
    S_UART_TX
  } top_state_type;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_WAIT,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_DONE
  } tx_state_type;

`ifdef UART_TX_PARITY_EN
  localparam int UART_BITS_PER_FRAME = 11;
`else
  localparam int UART_BITS_PER_FRAME = 10;
`endif

  typedef logic [UART_BITS_PER_FRAME-1:0] uart_frame_t;

  // Bit 0 leaves the pin first: start, data LSB first, optional parity, stop.
  function automatic uart_frame_t build_frame(input logic [7:0] data);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^data, data, 1'b0};
`else
    return {1'b1, data, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_serializer.sv
// One-byte UART transmitter: Load is taken only while Idle, each bit lasts
// CLKS_PER_BIT cycles, Byte_done marks the last cycle of the stop bit.
module uart_tx_serializer
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       TX,
  output logic       Byte_done,
  output logic       Idle
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(UART_BITS_PER_FRAME - 1);

  uart_frame_t       frame_q;
  logic              active_q;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic              bit_end;

  assign bit_end   = active_q && (baud_q == BAUD_LAST);
  assign Byte_done = bit_end && (bit_q == BIT_LAST);
  assign Idle      = !active_q;
  // Shift register resets to ones so the line idles high, even mid-frame.
  assign TX        = frame_q[0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      frame_q  <= '1;
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
    end else if (!active_q) begin
      if (Load) begin
        frame_q  <= build_frame(Data);
        active_q <= 1'b1;
        baud_q   <= '0;
        bit_q    <= '0;
      end
    end else if (bit_end) begin
      frame_q <= {1'b1, frame_q[UART_BITS_PER_FRAME-1:1]};
      baud_q  <= '0;
      bit_q   <= bit_q + 4'd1;
      if (bit_q == BIT_LAST) begin
        active_q <= 1'b0;
      end
    end else begin
      baud_q <= baud_q + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Dumps Word_count SRAM words out of UART_TX_O, high byte first; first start bit
// appears 2+SRAM_READ_LATENCY cycles after Start. Framing set by UART_TX_PARITY_EN.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 434,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int WAIT_W = $clog2(SRAM_READ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_READ_LATENCY - 1);

  tx_state_type      state_q;
  tx_state_type      state_d;
  logic [17:0]       count_q;
  logic [15:0]       word_q;
  logic [WAIT_W-1:0] wait_q;
  logic              busy_q;
  logic              ser_load;
  logic [7:0]        ser_data;
  logic              byte_done;
  logic              ser_idle;

  assign SRAM_we_n = 1'b1;
  assign Busy      = busy_q;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (ser_load),
    .Data     (ser_data),
    .TX       (UART_TX_O),
    .Byte_done(byte_done),
    .Idle     (ser_idle)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_TX_IDLE: begin
        if (Start) begin
          state_d = (Word_count == '0) ? S_TX_DONE : S_TX_READ;
        end
      end
      S_TX_READ:    state_d = S_TX_WAIT;
      S_TX_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_TX_SEND_HI;
        end
      end
      S_TX_SEND_HI: begin
        if (byte_done) begin
          state_d = S_TX_SEND_LO;
        end
      end
      S_TX_SEND_LO: begin
        if (byte_done) begin
          state_d = (count_q == 18'd1) ? S_TX_DONE : S_TX_READ;
        end
      end
      S_TX_DONE:    state_d = S_TX_IDLE;
      default:      state_d = S_TX_IDLE;
    endcase
  end

  // The serializer goes idle on the byte_done edge, so the low byte is
  // handed over exactly one cycle after the high byte finishes.
  always_comb begin
    ser_load = 1'b0;
    ser_data = word_q[15:8];
    Done     = 1'b0;
    case (state_q)
      S_TX_SEND_HI: ser_load = ser_idle;
      S_TX_SEND_LO: begin
        ser_load = ser_idle;
        ser_data = word_q[7:0];
      end
      S_TX_DONE:    Done = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      SRAM_address <= '0;
      count_q      <= '0;
      word_q       <= '0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_TX_IDLE: begin
          if (Start && (Word_count != '0)) begin
            SRAM_address <= Start_address;
            count_q      <= Word_count;
            busy_q       <= 1'b1;
          end
        end
        S_TX_READ: wait_q <= '0;
        S_TX_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            word_q <= SRAM_read_data;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_TX_SEND_LO: begin
          if (byte_done) begin
            SRAM_address <= SRAM_address + 18'd1;
            count_q      <= count_q - 18'd1;
          end
        end
        S_TX_DONE: busy_q <= 1'b0;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: SRAM model, sampling UART receiver and
// byte/address scoreboards; honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_sram_tx_interface;

  localparam int CLKS = 16;
  localparam int LAT  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME = BITS * CLKS;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  uart_sram_tx_interface #(
    .CLKS_PER_BIT(CLKS),
    .SRAM_READ_LATENCY(LAT)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Start         (Start),
    .Start_address (Start_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_read_data(SRAM_read_data),
    .SRAM_we_n     (SRAM_we_n),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #10 Clock = ~Clock;

  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_pipe [LAT];

  always @(posedge Clock) begin
    rd_pipe[0] <= mem.exists(SRAM_address) ? mem[SRAM_address] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign SRAM_read_data = rd_pipe[LAT-1];

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_bytes [$];
  logic [17:0] exp_addr [$];
  int          frame_starts [$];
  int          done_cycs [$];
  int          cyc = 0;
  int          start_cyc = 0;
  logic        addr_first = 1'b0;
  logic [17:0] addr_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rx_byte(input logic [10:0] f);
    logic [7:0] d;
    d = f[8:1];
    check("rx_start_bit", 32'(f[0]), 1'b0);
    check("rx_stop_bit", 32'(f[BITS-1]), 1);
`ifdef UART_TX_PARITY_EN
    check("rx_parity", 32'(f[9]), 32'(^d));
`endif
    check("rx_byte_expected", 32'(exp_bytes.size() > 0), 1);
    if (exp_bytes.size() > 0) check("rx_data", 32'(d), 32'(exp_bytes.pop_front()));
  endtask

  // Sampling monitor: runs 1 ns after every rising edge.
  logic        tx_prev = 1'b1;
  logic        rx_on = 1'b0;
  int          rx_cnt = 0;
  int          rx_bit = 0;
  logic [10:0] rx_sh = '1;

  initial begin
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      if (Done) done_cycs.push_back(cyc);
      if (Busy && !Done && (addr_first || SRAM_address !== addr_prev)) begin
        check("addr_issued", 32'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) check("addr_value", 32'(SRAM_address), 32'(exp_addr.pop_front()));
        addr_first = 1'b0;
      end
      addr_prev = SRAM_address;
      if (Reset) begin
        rx_on = 1'b0;
      end else if (!rx_on) begin
        if (tx_prev && !UART_TX_O) begin
          rx_on  = 1'b1;
          rx_cnt = 0;
          rx_bit = 0;
          rx_sh  = '1;
          frame_starts.push_back(cyc);
        end
      end else begin
        rx_cnt++;
      end
      if (rx_on && rx_cnt == CLKS / 2 + rx_bit * CLKS) begin
        rx_sh[rx_bit] = UART_TX_O;
        rx_bit++;
        if (rx_bit == BITS) begin
          rx_on = 1'b0;
          rx_byte(rx_sh);
        end
      end
      tx_prev = UART_TX_O;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic start_dump(input logic [17:0] a, input logic [17:0] n);
    logic [17:0] wa;
    logic [15:0] w;
    for (int i = 0; i < int'(n); i++) begin
      wa = a + 18'(i);
      w  = mem.exists(wa) ? mem[wa] : 16'hDEAD;
      exp_addr.push_back(wa);
      exp_bytes.push_back(w[15:8]);
      exp_bytes.push_back(w[7:0]);
    end
    frame_starts.delete();
    done_cycs.delete();
    addr_first    = 1'b1;
    Start         = 1'b1;
    Start_address = a;
    Word_count    = n;
    tick();
    Start     = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 32'(Busy), 1);
  endtask

  task automatic finish_dump(input int n);
    int budget;
    budget = n * 2 * (FRAME + 8) + 50;
    while (budget > 0 && done_cycs.size() == 0) begin
      tick();
      budget--;
    end
    check("done_seen", 32'(done_cycs.size() > 0), 1);
    if (done_cycs.size() > 0 && frame_starts.size() >= 2) begin
      check("first_latency", 32'(frame_starts[0] - start_cyc), 2 + LAT);
      check("hi_lo_spacing", 32'(frame_starts[1] - frame_starts[0]), FRAME + 1);
      check("done_after_stop", 32'(done_cycs[0] - frame_starts[$]), FRAME);
    end
    check("frame_count", 32'(frame_starts.size()), 2 * n);
    tick();
    check("done_width", 32'(Done), 0);
    check("busy_after_done", 32'(Busy), 0);
    check("bytes_left", 32'(exp_bytes.size()), 0);
    check("addrs_left", 32'(exp_addr.size()), 0);
  endtask

  initial begin
    repeat (60000) @(posedge Clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_low;
    int busy_hi;
    int done_hi;
    int we_low;
    Reset         = 1'b1;
    Start         = 1'b0;
    Start_address = '0;
    Word_count    = '0;
    mem[18'h00010] = 16'hA55A;
    mem[18'h3FFFE] = 16'h1234;
    mem[18'h3FFFF] = 16'h5678;
    mem[18'h00000] = 16'h9ABC;
    mem[18'h00100] = 16'h0703;
    mem[18'h00101] = 16'hC3E1;
    mem[18'h00200] = 16'hBEEF;
    mem[18'h00300] = 16'h3C5A;

    repeat (3) tick();
    check("rst_addr", 32'(SRAM_address), 0);
    check("rst_tx", 32'(UART_TX_O), 1);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    Reset = 1'b0;

    tx_low = 0; busy_hi = 0; done_hi = 0; we_low = 0;
    repeat (1000) begin
      tick();
      if (!UART_TX_O) tx_low++;
      if (Busy) busy_hi++;
      if (Done) done_hi++;
      if (!SRAM_we_n) we_low++;
    end
    check("idle_tx_low", 32'(tx_low), 0);
    check("idle_busy", 32'(busy_hi), 0);
    check("idle_done", 32'(done_hi), 0);
    check("idle_we_n", 32'(we_low), 0);

    start_dump(18'h00010, 18'd1);
    finish_dump(1);

    start_dump(18'h3FFFE, 18'd3);
    finish_dump(3);

    frame_starts.delete();
    done_cycs.delete();
    Start = 1'b1; Start_address = 18'h00055; Word_count = '0;
    tick();
    Start = 1'b0;
    check("zero_done", 32'(Done), 1);
    check("zero_busy", 32'(Busy), 0);
    busy_hi = 0;
    repeat (3 * FRAME) begin
      tick();
      if (Busy) busy_hi++;
    end
    check("zero_busy_never", 32'(busy_hi), 0);
    check("zero_no_frames", 32'(frame_starts.size()), 0);
    check("zero_done_count", 32'(done_cycs.size()), 1);

    start_dump(18'h00100, 18'd2);
    repeat (FRAME) tick();
    Start = 1'b1; Start_address = 18'h00200; Word_count = 18'd5;
    tick();
    Start = 1'b0;
    finish_dump(2);

    start_dump(18'h00300, 18'd1);
    repeat (2 + LAT + CLKS + CLKS / 2 - 1) tick();
    check("pre_rst_tx_low", 32'(UART_TX_O), 0);
    #1 Reset = 1'b1;
    #1;
    check("rst_async_tx", 32'(UART_TX_O), 1);
    check("rst_async_busy", 32'(Busy), 0);
    exp_bytes.delete();
    exp_addr.delete();
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    start_dump(18'h00010, 18'd1);
    finish_dump(1);

    repeat (10) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
